// File: rtl/sum_tx_pkg.sv
// Shared types and constants for the operand-sum UART sequencer.
// frame_char() maps a 5-bit sum and character index to the ASCII byte sent.
package sum_tx_pkg;

  typedef enum logic [2:0] {
    ST_COLLECT,
    ST_SETTLE,
    ST_SEND,
    ST_WAIT_ACK,
    ST_WAIT_DONE
  } state_t;

  localparam logic [7:0] ASCII_0  = 8'h30;
  localparam logic [7:0] ASCII_CR = 8'h0D;
  localparam logic [7:0] ASCII_LF = 8'h0A;

  localparam int FRAME_LEN_DIGITS = 2;
  localparam int FRAME_LEN_CRLF   = 4;

  // Sums above 30 keep tens at 3 so the units digit never wraps past '9'.
  function automatic logic [7:0] frame_char(input logic [4:0] sum, input logic [1:0] idx);
    logic [1:0] tens;
    logic [4:0] units;
    if (sum >= 5'd30)      tens = 2'd3;
    else if (sum >= 5'd20) tens = 2'd2;
    else if (sum >= 5'd10) tens = 2'd1;
    else                   tens = 2'd0;
    units = sum - (5'(tens) * 5'd10);
    case (idx)
      2'd0:    frame_char = ASCII_0 + {6'd0, tens};
      2'd1:    frame_char = ASCII_0 + {3'd0, units};
      2'd2:    frame_char = ASCII_CR;
      default: frame_char = ASCII_LF;
    endcase
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// Two-flop synchroniser and stability counter for one active-low button.
// o_press pulses for one cycle when the debounced level falls from 1 to 0.
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 250000
) (
  input  logic clk,
  input  logic reset_n,
  input  logic i_btn_n,
  output logic o_press
);

  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

  logic          r_sync1;
  logic          r_sync2;
  logic          r_level;
  logic          r_press;
  logic [CW-1:0] r_cnt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
      r_level <= 1'b1;
      r_press <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_sync1 <= i_btn_n;
      r_sync2 <= r_sync1;
      r_press <= 1'b0;
      // Any return to the accepted level restarts the stability count.
      if (r_sync2 == r_level) begin
        r_cnt <= '0;
      end else if (r_cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
        r_cnt   <= '0;
        r_level <= r_sync2;
        r_press <= r_level & ~r_sync2;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign o_press = r_press;

endmodule

// File: rtl/sum_tx_sequencer.sv
// Sequences operand capture strobes, then sends the latched sum over UART
// as two ASCII decimal digits with an optional CR LF trailer.
module sum_tx_sequencer
  import sum_tx_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter bit SEND_CRLF       = 1'b1,
  parameter int ACK_TIMEOUT     = 15
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       btn_a_n,
  input  logic       btn_b_n,
  input  logic [4:0] sum_in,
  input  logic       uart_tx_busy,
  output logic       save_a_n,
  output logic       save_b_n,
  output logic       uart_tx_en,
  output logic [7:0] uart_tx_data,
  output logic       have_a,
  output logic       have_b,
  output logic       seq_busy,
  output logic       frame_done
);

  localparam int         TW        = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
  localparam int         FRAME_LEN = SEND_CRLF ? FRAME_LEN_CRLF : FRAME_LEN_DIGITS;
  localparam logic [1:0] LAST_IDX  = 2'(FRAME_LEN - 1);

  // Reset asserts asynchronously but is released on a clock edge.
  logic [1:0] r_rst_sync;
  logic       w_rst_n;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_rst_sync <= 2'b00;
    else          r_rst_sync <= {r_rst_sync[0], 1'b1};
  end

  assign w_rst_n = r_rst_sync[1];

  logic [1:0] w_btn_n;
  logic [1:0] w_press;

  assign w_btn_n = {btn_b_n, btn_a_n};

  for (genvar gi = 0; gi < 2; gi++) begin : g_db
    btn_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_db (
      .clk     (clk),
      .reset_n (w_rst_n),
      .i_btn_n (w_btn_n[gi]),
      .o_press (w_press[gi])
    );
  end

  state_t        r_state,      w_state_next;
  logic [1:0]    r_idx,        w_idx_next;
  logic [TW-1:0] r_to_cnt,     w_to_cnt_next;
  logic [4:0]    r_sum_q,      w_sum_q_next;
  logic [1:0]    r_have,       w_have_next;
  logic [1:0]    r_save_n,     w_save_n_next;
  logic          r_tx_en,      w_tx_en_next;
  logic [7:0]    r_tx_data,    w_tx_data_next;
  logic          r_frame_done, w_frame_done_next;

  always_ff @(posedge clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_state      <= ST_COLLECT;
      r_idx        <= 2'd0;
      r_to_cnt     <= '0;
      r_sum_q      <= 5'd0;
      r_have       <= 2'b00;
      r_save_n     <= 2'b11;
      r_tx_en      <= 1'b0;
      r_tx_data    <= 8'h00;
      r_frame_done <= 1'b0;
    end else begin
      r_state      <= w_state_next;
      r_idx        <= w_idx_next;
      r_to_cnt     <= w_to_cnt_next;
      r_sum_q      <= w_sum_q_next;
      r_have       <= w_have_next;
      r_save_n     <= w_save_n_next;
      r_tx_en      <= w_tx_en_next;
      r_tx_data    <= w_tx_data_next;
      r_frame_done <= w_frame_done_next;
    end
  end

  always_comb begin
    w_state_next      = r_state;
    w_idx_next        = r_idx;
    w_to_cnt_next     = r_to_cnt;
    w_sum_q_next      = r_sum_q;
    w_have_next       = r_have;
    w_save_n_next     = 2'b11;
    w_tx_en_next      = 1'b0;
    w_tx_data_next    = r_tx_data;
    w_frame_done_next = 1'b0;
    case (r_state)
      ST_COLLECT: begin
        w_save_n_next = ~w_press;
        w_have_next   = r_have | w_press;
        if (&(r_have | w_press)) w_state_next = ST_SETTLE;
      end
      ST_SETTLE: begin
        w_sum_q_next = sum_in;
        w_state_next = ST_SEND;
      end
      ST_SEND: begin
        if (!uart_tx_busy) begin
          w_tx_en_next   = 1'b1;
          w_tx_data_next = frame_char(r_sum_q, r_idx);
          w_to_cnt_next  = '0;
          w_state_next   = ST_WAIT_ACK;
        end
      end
      ST_WAIT_ACK: begin
        // A request the transmitter never acknowledged is re-issued unchanged.
        if (uart_tx_busy)                           w_state_next  = ST_WAIT_DONE;
        else if (r_to_cnt == TW'(ACK_TIMEOUT - 1)) w_state_next  = ST_SEND;
        else                                        w_to_cnt_next = r_to_cnt + 1'b1;
      end
      ST_WAIT_DONE: begin
        if (!uart_tx_busy) begin
          if (r_idx == LAST_IDX) begin
            w_frame_done_next = 1'b1;
            w_have_next       = 2'b00;
            w_idx_next        = 2'd0;
            w_state_next      = ST_COLLECT;
          end else begin
            w_idx_next   = r_idx + 2'd1;
            w_state_next = ST_SEND;
          end
        end
      end
      default: w_state_next = ST_COLLECT;
    endcase
  end

  assign save_a_n     = r_save_n[0];
  assign save_b_n     = r_save_n[1];
  assign uart_tx_en   = r_tx_en;
  assign uart_tx_data = r_tx_data;
  assign have_a       = r_have[0];
  assign have_b       = r_have[1];
  assign seq_busy     = (r_state != ST_COLLECT);
  assign frame_done   = r_frame_done;

endmodule

// File: tb/tb_sum_tx_sequencer.sv
// Bench for sum_tx_sequencer: one CR LF instance and one digits-only instance,
// each with a uart_tx busy model; frames are checked against a decimal model.
module tb_sum_tx_sequencer;

  localparam int DB       = 4;
  localparam int LAT      = 2 + DB + 1;
  localparam int TO       = 15;
  localparam int BUSY_LEN = 10;

  logic       clk     = 1'b0;
  logic       reset_n = 1'b0;
  logic [4:0] sum_in  = 5'd0;
  logic [1:0] bt_a_n  = 2'b11;
  logic [1:0] bt_b_n  = 2'b11;
  logic [1:0] busy, save_a_n, save_b_n, tx_en, have_a, have_b, seq_busy, frame_done;
  logic [7:0] tx_data [2];

  int checks = 0;
  int passed = 0;
  int fails  = 0;
  int cyc    = 0;
  int busy_cnt [2] = '{0, 0};
  int req_cnt  [2] = '{0, 0};
  int sa_cnt   [2] = '{0, 0};
  int sb_cnt   [2] = '{0, 0};
  int fd_cnt   [2] = '{0, 0};
  int ignore_idx = -1;
  logic [7:0] tx_q0 [$];
  logic [7:0] tx_q1 [$];
  int         tx_c0 [$];

  always #5 clk = ~clk;

  sum_tx_sequencer #(.DEBOUNCE_CYCLES(DB), .SEND_CRLF(1'b1), .ACK_TIMEOUT(TO)) dut (
    .clk(clk), .reset_n(reset_n), .btn_a_n(bt_a_n[0]), .btn_b_n(bt_b_n[0]),
    .sum_in(sum_in), .uart_tx_busy(busy[0]), .save_a_n(save_a_n[0]), .save_b_n(save_b_n[0]),
    .uart_tx_en(tx_en[0]), .uart_tx_data(tx_data[0]), .have_a(have_a[0]), .have_b(have_b[0]),
    .seq_busy(seq_busy[0]), .frame_done(frame_done[0])
  );

  sum_tx_sequencer #(.DEBOUNCE_CYCLES(DB), .SEND_CRLF(1'b0), .ACK_TIMEOUT(TO)) dut2 (
    .clk(clk), .reset_n(reset_n), .btn_a_n(bt_a_n[1]), .btn_b_n(bt_b_n[1]),
    .sum_in(sum_in), .uart_tx_busy(busy[1]), .save_a_n(save_a_n[1]), .save_b_n(save_b_n[1]),
    .uart_tx_en(tx_en[1]), .uart_tx_data(tx_data[1]), .have_a(have_a[1]), .have_b(have_b[1]),
    .seq_busy(seq_busy[1]), .frame_done(frame_done[1])
  );

  assign busy[0] = (busy_cnt[0] != 0);
  assign busy[1] = (busy_cnt[1] != 0);

  // Transmitter model: busy rises the cycle after a request and holds 10 cycles.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    for (int k = 0; k < 2; k++) begin
      if (tx_en[k]) begin
        req_cnt[k] <= req_cnt[k] + 1;
        if (!(k == 0 && req_cnt[0] == ignore_idx)) busy_cnt[k] <= BUSY_LEN;
      end else if (busy_cnt[k] > 0) begin
        busy_cnt[k] <= busy_cnt[k] - 1;
      end
    end
  end

  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (!save_a_n[k]) sa_cnt[k] = sa_cnt[k] + 1;
      if (!save_b_n[k]) sb_cnt[k] = sb_cnt[k] + 1;
      if (frame_done[k]) fd_cnt[k] = fd_cnt[k] + 1;
    end
    if (tx_en[0]) begin
      tx_q0.push_back(tx_data[0]);
      tx_c0.push_back(cyc);
    end
    if (tx_en[1]) tx_q1.push_back(tx_data[1]);
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input int obs, input int exp);
    checks = checks + 1;
    assert (obs === exp) passed = passed + 1;
    else begin
      fails = fails + 1;
      $error("FAIL %s: observed %0d required %0d", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] exp_char(input int s, input int i);
    int tens, units;
    tens = s / 10;
    if (tens > 3) tens = 3;
    units = s - 10 * tens;
    case (i)
      0:       return 8'(48 + tens);
      1:       return 8'(48 + units);
      2:       return 8'h0D;
      default: return 8'h0A;
    endcase
  endfunction

  function automatic int qsize(input int k);
    return (k == 0) ? tx_q0.size() : tx_q1.size();
  endfunction

  function automatic int qchar(input int k, input int i);
    return (k == 0) ? int'(tx_q0[i]) : int'(tx_q1[i]);
  endfunction

  function automatic logic strobe(input int k, input int w);
    return (w == 0) ? !save_a_n[k] : !save_b_n[k];
  endfunction

  function automatic int have(input int k, input int w);
    return (w == 0) ? int'(have_a[k]) : int'(have_b[k]);
  endfunction

  task automatic ncyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic set_btn(input int k, input int w, input logic v);
    if (w == 0) bt_a_n[k] = v;
    else        bt_b_n[k] = v;
  endtask

  task automatic wait_strobe(input int k, input int w, input int t0, input string tag);
    int got;
    got = -1;
    for (int i = 0; i < LAT + 8 && got < 0; i++) begin
      @(negedge clk);
      if (strobe(k, w)) begin
        got = cyc;
        check({tag, "_have"}, have(k, w), 1);
      end
    end
    check({tag, "_latency"}, got - t0, LAT);
  endtask

  task automatic press(input int k, input int w, input string tag);
    int t0;
    @(negedge clk);
    set_btn(k, w, 1'b0);
    t0 = cyc;
    wait_strobe(k, w, t0, tag);
    ncyc(3);
    set_btn(k, w, 1'b1);
    ncyc(DB + 4);
  endtask

  task automatic wait_frame(input int k, input int fd0);
    for (int i = 0; i < 800 && fd_cnt[k] == fd0; i++) @(negedge clk);
    ncyc(2);
  endtask

  task automatic frame_checks(input int k, input int s, input string tag, input bit retry,
                              input int n0, input int sa0, input int sb0, input int fd0);
    logic [7:0] e [5];
    int nexp;
    nexp = 0;
    for (int i = 0; i < ((k == 0) ? 4 : 2); i++) begin
      e[nexp] = exp_char(s, i);
      nexp = nexp + 1;
      if (retry && i == 0) begin
        e[nexp] = exp_char(s, 0);
        nexp = nexp + 1;
      end
    end
    check({tag, "_nchars"}, qsize(k) - n0, nexp);
    for (int i = 0; i < nexp; i++)
      if (n0 + i < qsize(k)) check($sformatf("%s_char%0d", tag, i), qchar(k, n0 + i), int'(e[i]));
    if (retry && tx_c0.size() >= n0 + 2)
      check({tag, "_retry_gap"}, tx_c0[n0 + 1] - tx_c0[n0], TO + 1);
    check({tag, "_frame_done"}, fd_cnt[k] - fd0, 1);
    check({tag, "_save_a_cnt"}, sa_cnt[k] - sa0, 1);
    check({tag, "_save_b_cnt"}, sb_cnt[k] - sb0, 1);
    check({tag, "_have_a_clr"}, int'(have_a[k]), 0);
    check({tag, "_have_b_clr"}, int'(have_b[k]), 0);
    check({tag, "_seq_idle"}, int'(seq_busy[k]), 0);
    $display("frame %s dut%0d sum=%0d chars=%0d", tag, k, s, qsize(k) - n0);
  endtask

  // mode 0: plain presses, 1: bouncing A button, 2: first request unacknowledged
  task automatic run_frame(input int k, input int s, input string tag, input int mode);
    int n0, sa0, sb0, fd0, t0;
    sum_in = 5'(s);
    @(negedge clk);
    n0 = qsize(k); sa0 = sa_cnt[k]; sb0 = sb_cnt[k]; fd0 = fd_cnt[k];
    if (mode == 2) ignore_idx = req_cnt[0];
    if (mode == 1) begin
      set_btn(k, 0, 1'b0);
      ncyc(2);
      set_btn(k, 0, 1'b1);
      ncyc(2);
      set_btn(k, 0, 1'b0);
      t0 = cyc;
      wait_strobe(k, 0, t0, {tag, "_a"});
      ncyc(3);
      set_btn(k, 0, 1'b1);
      ncyc(DB + 4);
    end else begin
      press(k, 0, {tag, "_a"});
    end
    press(k, 1, {tag, "_b"});
    wait_frame(k, fd0);
    ignore_idx = -1;
    frame_checks(k, s, tag, (mode == 2), n0, sa0, sb0, fd0);
  endtask

  initial begin
    int s, n0, sa0, sb0, sa1, fd0, t0, got;
    int sums [5] = '{0, 9, 10, 29, 31};

    ncyc(3);
    check("rst_save_a_n", int'(save_a_n[0]), 1);
    check("rst_save_b_n", int'(save_b_n[0]), 1);
    check("rst_tx_en", int'(tx_en[0]), 0);
    check("rst_tx_data", int'(tx_data[0]), 0);
    check("rst_have", int'({have_a[0], have_b[0]}), 0);
    check("rst_seq_busy", int'(seq_busy[0]), 0);
    check("rst_frame_done", int'(frame_done[0]), 0);
    reset_n = 1'b1;
    ncyc(4);

    run_frame(0, 2 + 3, "sum5", 0);
    foreach (sums[i]) run_frame(0, sums[i], $sformatf("dir%0d", sums[i]), 0);
    for (int i = 0; i < 2; i++) run_frame(0, int'($urandom_range(0, 30)), $sformatf("rnd%0d", i), 0);

    run_frame(1, 15 + 15, "nocrlf30", 0);
    run_frame(1, int'($urandom_range(0, 30)), "nocrlf_rnd", 0);

    run_frame(0, int'($urandom_range(0, 30)), "bounce", 1);

    // Simultaneous presses, then a press while the frame is being sent.
    s = int'($urandom_range(0, 30));
    sum_in = 5'(s);
    @(negedge clk);
    n0 = qsize(0); sa0 = sa_cnt[0]; sb0 = sb_cnt[0]; fd0 = fd_cnt[0];
    set_btn(0, 0, 1'b0);
    set_btn(0, 1, 1'b0);
    t0 = cyc;
    got = -1;
    for (int i = 0; i < LAT + 8 && got < 0; i++) begin
      @(negedge clk);
      if (!save_a_n[0]) begin
        got = cyc;
        check("simul_b_same_cycle", int'(save_b_n[0]), 0);
      end
    end
    check("simul_latency", got - t0, LAT);
    ncyc(3);
    set_btn(0, 0, 1'b1);
    set_btn(0, 1, 1'b1);
    for (int i = 0; i < 200 && qsize(0) == n0; i++) @(negedge clk);
    sa1 = sa_cnt[0];
    set_btn(0, 0, 1'b0);
    ncyc(10);
    set_btn(0, 0, 1'b1);
    ncyc(DB + 4);
    check("send_press_no_strobe", sa_cnt[0] - sa1, 0);
    check("send_press_have_a", int'(have_a[0]), 1);
    check("send_press_have_b", int'(have_b[0]), 1);
    check("send_press_seq_busy", int'(seq_busy[0]), 1);
    wait_frame(0, fd0);
    frame_checks(0, s, "simul", 1'b0, n0, sa0, sb0, fd0);

    run_frame(0, int'($urandom_range(0, 30)), "timeout", 2);

    // Reset while waiting for the second character to finish.
    s = int'($urandom_range(0, 30));
    sum_in = 5'(s);
    @(negedge clk);
    n0 = qsize(0); fd0 = fd_cnt[0];
    press(0, 0, "abort_a");
    press(0, 1, "abort_b");
    for (int i = 0; i < 200 && qsize(0) < n0 + 2; i++) @(negedge clk);
    ncyc(3);
    check("abort_pre_busy", int'(seq_busy[0]), 1);
    #2 reset_n = 1'b0;
    #1;
    check("abort_save_a_n", int'(save_a_n[0]), 1);
    check("abort_save_b_n", int'(save_b_n[0]), 1);
    check("abort_tx_en", int'(tx_en[0]), 0);
    check("abort_tx_data", int'(tx_data[0]), 0);
    check("abort_have", int'({have_a[0], have_b[0]}), 0);
    check("abort_seq_busy", int'(seq_busy[0]), 0);
    check("abort_frame_done", int'(frame_done[0]), 0);
    ncyc(3);
    reset_n = 1'b1;
    check("abort_no_frame_done", fd_cnt[0] - fd0, 0);
    ncyc(4);
    run_frame(0, int'($urandom_range(0, 30)), "post_reset", 0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
